alu: RTL and testbench



---
 rtl/alu.sv | 155 +++++++++++++++
 tb/tb_alu.sv | 129 ++++++++++++
 2 files changed

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- 16-bit integer ALU with registered result and condition flags for the
// CompactRISC16 datapath. A combinational core computes one of twelve
// operations. Result and flags are captured together on each enabled rising
// clock edge.
//
// Ports:
//   I_CLK      in   1   clock, rising edge
//   I_NRESET   in   1   asynchronous active-low reset (clears O_C / O_STATUS)
//   I_ENABLE   in   1   capture enable; outputs hold while low
//   I_A        in  16   operand A (source / shift value)
//   I_B        in  16   operand B (destination operand / shift amount)
//   I_OPCODE   in   4   operation select (12..15 give zero result and flags)
//   O_C        out 16   registered result
//   O_STATUS   out  5   registered flags {N, Z, F, L, C}
//
// Build option:
//   ALU_ARSH_SIGN_EXT_EN -- when defined, ARSH is a true arithmetic right shift
//   that fills with A[15]. When undefined, ARSH behaves like RSH (zero fill).
// -----------------------------------------------------------------------------
module alu (
   input  logic        I_CLK,
   input  logic        I_NRESET,
   input  logic        I_ENABLE,
   input  logic [15:0] I_A,
   input  logic [15:0] I_B,
   input  logic [3:0]  I_OPCODE,
   output logic [15:0] O_C,
   output logic [4:0]  O_STATUS
);

   localparam int DATA_W = 16;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_ADDC = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_NOT  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_LSH  = 4'd8;
   localparam logic [3:0] OP_RSH  = 4'd9;
   localparam logic [3:0] OP_ALSH = 4'd10;
   localparam logic [3:0] OP_ARSH = 4'd11;

   // The shift amount is the full 16-bit B. Any amount of 16 or more shifts
   // everything out, so only B[3:0] matters once B[15:4] is zero.
   function automatic logic [DATA_W-1:0] shl(input logic [DATA_W-1:0] v,
                                             input logic [DATA_W-1:0] amt);
      if (amt[15:4] != 12'd0) shl = '0;
      else                    shl = v << amt[3:0];
   endfunction

   function automatic logic [DATA_W-1:0] shr(input logic [DATA_W-1:0] v,
                                             input logic [DATA_W-1:0] amt);
      if (amt[15:4] != 12'd0) shr = '0;
      else                    shr = v >> amt[3:0];
   endfunction

`ifdef ALU_ARSH_SIGN_EXT_EN
   function automatic logic [DATA_W-1:0] sar(input logic [DATA_W-1:0] v,
                                             input logic [DATA_W-1:0] amt);
      logic signed [DATA_W-1:0] vs;
      vs = $signed(v);
      if (amt[15:4] != 12'd0) sar = {DATA_W{v[DATA_W-1]}};
      else                    sar = vs >>> amt[3:0];
   endfunction
`endif

   logic [DATA_W-1:0] r;
   logic              flag_c, flag_l, flag_f, flag_z, flag_n;
   logic              valid_op;
   logic [DATA_W-1:0] c_d, c_q;
   logic [4:0]        status_d, status_q;

   // Combinational core
   always_comb begin
      r        = '0;
      flag_c   = 1'b0;
      flag_l   = 1'b0;
      flag_f   = 1'b0;
      flag_n   = 1'b0;
      valid_op = 1'b1;

      case (I_OPCODE)
         OP_ADD: begin
            r      = I_A + I_B;
            flag_f = (I_A[15] == I_B[15]) && (r[15] != I_A[15]);
            flag_n = r[15];
         end
         OP_ADDC: begin
            r      = I_A + I_B + 16'd1;
            flag_f = (I_A[15] == I_B[15]) && (r[15] != I_A[15]);
            // Sign of the true 17-bit sum, not simply R[15].
            flag_n = ((I_A[15] != I_B[15]) && r[15]) || (I_A[15] && I_B[15]);
         end
         OP_MUL: begin
            // The low 16 bits of a two's-complement product equal those of
            // the unsigned product, so no sign extension is needed.
            r      = I_A * I_B;
            flag_n = r[15];
         end
         OP_SUB: begin
            r      = I_B - I_A;
            flag_f = (I_A[15] != I_B[15]) && (r[15] != I_B[15]);
            flag_n = $signed(I_B) < $signed(I_A);
            flag_l = I_B < I_A;
         end
         OP_NOT:  begin r = ~I_A;          flag_n = r[15]; end
         OP_AND:  begin r = I_A & I_B;     flag_n = r[15]; end
         OP_OR:   begin r = I_A | I_B;     flag_n = r[15]; end
         OP_XOR:  begin r = I_A ^ I_B;     flag_n = r[15]; end
         OP_LSH,
         OP_ALSH: begin r = shl(I_A, I_B); flag_n = r[15]; end
         OP_RSH:  begin r = shr(I_A, I_B); flag_n = r[15]; end
         OP_ARSH: begin
`ifdef ALU_ARSH_SIGN_EXT_EN
            r = sar(I_A, I_B);
`else
            r = shr(I_A, I_B);
`endif
            flag_n = r[15];
         end
         default: valid_op = 1'b0;
      endcase

      // Reserved opcodes clear every flag, including Z.
      flag_z = valid_op && (r == '0);
   end

   // Output register next-state: hold while disabled
   always_comb begin
      c_d      = c_q;
      status_d = status_q;
      if (I_ENABLE) begin
         c_d      = r;
         status_d = {flag_n, flag_z, flag_f, flag_l, flag_c};
      end
   end

   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         c_q      <= '0;
         status_q <= '0;
      end else begin
         c_q      <= c_d;
         status_q <= status_d;
      end
   end

   assign O_C      = c_q;
   assign O_STATUS = status_q;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- directed-vector bench for alu. Each vector is applied on a falling
// edge, captured on the next rising edge, and checked on the following falling
// edge against hand-computed result and flag values.
// O_STATUS bit order is {N, Z, F, L, C}.
// -----------------------------------------------------------------------------
module tb_alu;

   logic        clk;
   logic        nreset;
   logic        enable;
   logic [15:0] a, b;
   logic [3:0]  opcode;
   logic [15:0] o_c;
   logic [4:0]  o_status;

   int checks = 0;
   int errors = 0;

   alu dut (
      .I_CLK    (clk),
      .I_NRESET (nreset),
      .I_ENABLE (enable),
      .I_A      (a),
      .I_B      (b),
      .I_OPCODE (opcode),
      .O_C      (o_c),
      .O_STATUS (o_status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp_v);
      end
   endtask

   // Apply one operation, let one rising edge capture it, then check.
   task automatic run_op(input string tag, input logic [3:0] op,
                         input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] exp_c, input logic [4:0] exp_s);
      opcode = op;
      a      = va;
      b      = vb;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_c"}, o_c, exp_c);
      check({tag, "_s"}, {11'd0, o_status}, {11'd0, exp_s});
   endtask

   initial begin
      nreset = 1'b0;
      enable = 1'b1;
      a      = '0;
      b      = '0;
      opcode = 4'd0;

      #1;
      check("rst_c", o_c, 16'h0000);
      check("rst_s", {11'd0, o_status}, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      nreset = 1'b1;

      run_op("add_basic", 4'd0, 16'h0001, 16'h0002, 16'h0003, 5'b00000);
      run_op("add_ovf",   4'd0, 16'h7C00, 16'h0400, 16'h8000, 5'b10100);
      run_op("add_zero",  4'd0, 16'hFFFF, 16'h0001, 16'h0000, 5'b01000);
      run_op("addc",      4'd1, 16'hFC00, 16'h0400, 16'h0001, 5'b00000);
      run_op("addc_neg",  4'd1, 16'h8000, 16'h8000, 16'h0001, 5'b10100);
      run_op("sub_nl",    4'd3, 16'h0400, 16'h0000, 16'hFC00, 5'b10010);
      run_op("sub_ovf",   4'd3, 16'h8000, 16'h0400, 16'h8400, 5'b00110);
      run_op("mul_z",     4'd2, 16'hFC00, 16'h0400, 16'h0000, 5'b01000);
      run_op("mul_neg",   4'd2, 16'hFFFD, 16'h0005, 16'hFFF1, 5'b10000);
      run_op("and",       4'd5, 16'hFC00, 16'h0C00, 16'h0C00, 5'b00000);
      run_op("or",        4'd6, 16'h00F0, 16'h8001, 16'h80F1, 5'b10000);
      run_op("xor",       4'd7, 16'hAAAA, 16'hAAAA, 16'h0000, 5'b01000);
      run_op("not",       4'd4, 16'h0400, 16'h1234, 16'hFBFF, 5'b10000);
      run_op("lsh",       4'd8, 16'h0400, 16'h0004, 16'h4000, 5'b00000);
      run_op("lsh_big",   4'd8, 16'h0400, 16'h0400, 16'h0000, 5'b01000);
      run_op("lsh_15",    4'd8, 16'h0001, 16'h000F, 16'h8000, 5'b10000);
      run_op("alsh",      4'd10, 16'h0003, 16'h0002, 16'h000C, 5'b00000);
      run_op("rsh",       4'd9, 16'h8000, 16'h0004, 16'h0800, 5'b00000);
      run_op("rsh_big",   4'd9, 16'h8000, 16'h0010, 16'h0000, 5'b01000);
`ifdef ALU_ARSH_SIGN_EXT_EN
      run_op("arsh",      4'd11, 16'h8000, 16'h0004, 16'hF800, 5'b10000);
      run_op("arsh_big",  4'd11, 16'h8000, 16'h0014, 16'hFFFF, 5'b10000);
`else
      run_op("arsh",      4'd11, 16'h8000, 16'h0004, 16'h0800, 5'b00000);
      run_op("arsh_big",  4'd11, 16'h8000, 16'h0014, 16'h0000, 5'b01000);
`endif

      // Asynchronous reset mid-stream: outputs clear without any clock edge.
      run_op("pre_rst",   4'd4, 16'h0000, 16'h0000, 16'hFFFF, 5'b10000);
      #2;
      nreset = 1'b0;
      #1;
      check("async_rst_c", o_c, 16'h0000);
      check("async_rst_s", {11'd0, o_status}, 16'h0000);
      @(negedge clk);
      check("rst_hold_c", o_c, 16'h0000);
      nreset = 1'b1;
      run_op("post_rst",  4'd0, 16'h0001, 16'h0002, 16'h0003, 5'b00000);

      // Enable low: outputs hold while inputs change.
      run_op("pre_hold",  4'd4, 16'h0400, 16'h0000, 16'hFBFF, 5'b10000);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         opcode = 4'(i + 5);
         a      = 16'h1111 * 16'(i + 1);
         b      = 16'h00FF;
         @(posedge clk);
         @(negedge clk);
         check("hold_c", o_c, 16'hFBFF);
         check("hold_s", {11'd0, o_status}, 16'h0010);
      end
      enable = 1'b1;

      run_op("op13",      4'd13, 16'h1234, 16'h5678, 16'h0000, 5'b00000);
      run_op("op15",      4'd15, 16'h0000, 16'h0000, 16'h0000, 5'b00000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
